fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Circular instruction fetch queue between the fetch unit and decode.
// Entries hold a {pc, instr} pair and leave in strict push order.
//
// Parameters
//   DEPTH  number of entries (power of two, 2..16)
//   XLEN   width of the pc and instruction fields
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high; clears pointers and count
//   flush      redirect; discards every stored entry
//   valid_in   fetch unit offers an entry
//   ready_in   queue can accept an entry (!full && !flush && !reset)
//   pc_in      pc of the offered entry
//   instr_in   instruction word of the offered entry
//   valid_out  head entry is presented to decode
//   ready_out  decode accepts the head entry
//   pc_out     pc of the head entry (don't-care while valid_out is 0)
//   instr_out  instruction of the head entry (don't-care while valid_out is 0)
//   count      number of stored entries
//   full       count == DEPTH
//   empty      count == 0
//
// Build option
//   FETCH_QUEUE_BYPASS_EN  when defined, an offer into an empty queue is shown
//                          to decode in the same cycle; if decode takes it,
//                          it is never written into storage.
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       valid_in,
   output logic                       ready_in,
   input  logic [XLEN-1:0]            pc_in,
   input  logic [XLEN-1:0]            instr_in,
   output logic                       valid_out,
   input  logic                       ready_out,
   output logic [XLEN-1:0]            pc_out,
   output logic [XLEN-1:0]            instr_out,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;

   logic empty_q;
   logic full_q;
   logic push;
   logic pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty_q = (count_q == '0);
   assign full_q  = (count_q == CW'(DEPTH));

   // Status outputs read as the reset state for the whole reset cycle, even
   // before the clearing edge has been seen by the registers.
   assign count    = reset ? '0 : count_q;
   assign full     = full_q && !reset;
   assign empty    = empty_q || reset;

   // ready_in looks only at registered fullness plus flush/reset, so a pop
   // from a full queue frees a slot one cycle later.
   assign ready_in = !full_q && !flush && !reset;

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypass;

   assign bypass    = empty_q && valid_in && !flush && !reset;
   assign valid_out = (!empty_q || valid_in) && !flush && !reset;
   assign pc_out    = empty_q ? pc_in    : pc_mem[rd_ptr];
   assign instr_out = empty_q ? instr_in : instr_mem[rd_ptr];

   // A bypassed entry consumed by decode this cycle never touches storage.
   assign push = valid_in && ready_in && !(bypass && ready_out);
   assign pop  = !empty_q && valid_out && ready_out;
`else
   assign valid_out = !empty_q && !flush && !reset;
   assign pc_out    = pc_mem[rd_ptr];
   assign instr_out = instr_mem[rd_ptr];

   assign push = valid_in && ready_in;
   assign pop  = valid_out && ready_out;
`endif

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is intentionally not reset; only pointers/count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= pc_in;
         instr_mem[wr_ptr] <= instr_in;
      end
   end

endmodule
